// File: rtl/ysyx_24090012_wb_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_24090012_wb_arbiter
//
// Write-back arbiter. It merges two register-file write requesters (EXU on
// port 0, LSU on port 1) into one register-file write port. A 1-bit
// round-robin pointer breaks ties. An accepted write is held in
// rf_waddr/rf_wdata/rf_src until the register file takes it. Writes to
// register 0 are consumed without a register-file cycle.
//
// Ports
//   clock, reset              rising-edge clock, async active-low reset
//   req0_valid/ready/waddr/wdata   EXU write request
//   req1_valid/ready/waddr/wdata   LSU write request
//   rf_valid/ready/waddr/wdata/src register-file write port (src: 0=EXU 1=LSU)
//   raddr1, raddr2            IDU read indices
//   hazard1, hazard2          held write targets raddr1 / raddr2
//   grant_cnt0, grant_cnt1    per-requester grant counters
//
// Build option
//   YSYX_24090012_WBARB_STAT_EN  when defined, grant_cntN counts every accepted
//                                reqN handshake (wrapping); otherwise both are 0.
// ---------------------------------------------------------------------------
module ysyx_24090012_wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [ADDR_WIDTH-1:0] req0_waddr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [ADDR_WIDTH-1:0] req1_waddr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  rf_valid,
    input  logic                  rf_ready,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  rf_src,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    output logic                  hazard1,
    output logic                  hazard2,
    output logic [31:0]           grant_cnt0,
    output logic [31:0]           grant_cnt1
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                  state, next_state;
    logic                    ptr;        // favoured requester on a tie
    logic                    grant;      // requester selected this cycle
    logic                    accept;     // a request handshake completes
    logic [ADDR_WIDTH-1:0]   acc_waddr;
    logic [DATA_WIDTH-1:0]   acc_wdata;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            state <= next_state;
        end
    end

    // Next-state logic and arbitration.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case leaves one unassigned and infers a latch.
        next_state = state;
        grant      = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        acc_waddr  = '0;
        acc_wdata  = '0;
        case (state)
            IDLE: begin
                // A lone valid wins; on a tie the pointer decides.
                grant      = (req0_valid && req1_valid) ? ptr : req1_valid;
                // Readies are gated by reset so nothing is offered while the
                // block is held in reset.
                req0_ready = reset && req0_valid && !grant;
                req1_ready = reset && req1_valid && grant;
                accept     = req0_ready || req1_ready;
                acc_waddr  = grant ? req1_waddr : req0_waddr;
                acc_wdata  = grant ? req1_wdata : req0_wdata;
                if (accept && (acc_waddr != '0)) begin
                    next_state = HOLD;
                end
            end
            HOLD: begin
                if (rf_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign rf_valid = (state == HOLD);

    // Hazards only exist while a write is pending; register 0 never aliases.
    assign hazard1 = rf_valid && (rf_waddr == raddr1) && (raddr1 != '0);
    assign hazard2 = rf_valid && (rf_waddr == raddr2) && (raddr2 != '0);

    // Held write and round-robin pointer. The held fields keep their last
    // value in IDLE; only rf_valid says whether they mean anything.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // NOTE: the held-write fields are reset too, because they are
            // visible outputs and must read as zero straight out of reset.
            ptr      <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            rf_src   <= 1'b0;
        end else begin
            if (accept) begin
                if (acc_waddr != '0) begin
                    rf_waddr <= acc_waddr;
                    rf_wdata <= acc_wdata;
                    rf_src   <= grant;
                end else begin
                    // A write to register 0 is dropped but still takes a turn.
                    ptr <= ~ptr;
                end
            end
            if (rf_valid && rf_ready) begin
                ptr <= ~rf_src;
            end
        end
    end

`ifdef YSYX_24090012_WBARB_STAT_EN
    logic [31:0] cnt0_q, cnt1_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (req0_valid && req0_ready) cnt0_q <= cnt0_q + 32'd1;
            if (req1_valid && req1_ready) cnt1_q <= cnt1_q + 32'd1;
        end
    end

    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;
`else
    assign grant_cnt0 = '0;
    assign grant_cnt1 = '0;
`endif

endmodule

// File: tb/tb_ysyx_24090012_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ysyx_24090012_wb_arbiter
//
// Self-checking bench for the write-back arbiter. A transaction-level model
// (pending write, favoured requester, grant tallies) predicts every output.
// Directed scenarios cover the single write, alternation, back-pressure,
// register-0 writes, hazards and asynchronous reset; a randomized run
// compares all outputs against the model every cycle.
// ---------------------------------------------------------------------------
module tb_ysyx_24090012_wb_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;
`ifdef YSYX_24090012_WBARB_STAT_EN
    localparam logic [31:0] STAT_MASK = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] STAT_MASK = 32'h0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [AW-1:0] req0_waddr = '0, req1_waddr = '0;
    logic [DW-1:0] req0_wdata = '0, req1_wdata = '0;
    logic          rf_valid, rf_src;
    logic          rf_ready = 1'b0;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [AW-1:0] raddr1 = '0, raddr2 = '0;
    logic          hazard1, hazard2;
    logic [31:0]   grant_cnt0, grant_cnt1;

    int checks = 0;
    int errors = 0;

    // Reference model: one pending write slot plus the arbitration pointer.
    bit            m_hold;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    bit            m_src;
    bit            m_ptr;
    logic [31:0]   m_cnt0, m_cnt1;

    ysyx_24090012_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_waddr(req0_waddr), .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_waddr(req1_waddr), .req1_wdata(req1_wdata),
        .rf_valid(rf_valid), .rf_ready(rf_ready),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_src(rf_src),
        .raddr1(raddr1), .raddr2(raddr2),
        .hazard1(hazard1), .hazard2(hazard2),
        .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
    );

    always #5 clock = ~clock;

    // Who the model says wins this cycle (no winner while a write is pending).
    function automatic bit win0();
        return !m_hold && req0_valid && (!req1_valid || !m_ptr);
    endfunction
    function automatic bit win1();
        return !m_hold && req1_valid && (!req0_valid || m_ptr);
    endfunction

    task automatic model_reset();
        m_hold = 0; m_addr = '0; m_data = '0; m_src = 0; m_ptr = 0;
        m_cnt0 = '0; m_cnt1 = '0;
    endtask

    // Advance the model by one clock edge using the inputs present now.
    task automatic model_update();
        bit            w0, w1;
        logic [AW-1:0] a;
        w0 = win0();
        w1 = win1();
        if (m_hold) begin
            if (rf_ready) begin
                m_hold = 0;
                m_ptr  = !m_src;
            end
        end else if (w0 || w1) begin
            if (w0) m_cnt0 = m_cnt0 + 1; else m_cnt1 = m_cnt1 + 1;
            a = w1 ? req1_waddr : req0_waddr;
            if (a != 0) begin
                m_hold = 1;
                m_addr = a;
                m_data = w1 ? req1_wdata : req0_wdata;
                m_src  = w1;
            end else begin
                m_ptr = !m_ptr;
            end
        end
    endtask

    // One clock cycle; returns 1 ns after the rising edge.
    task automatic tick();
        model_update();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req1_valid = 0; rf_ready = 0; raddr1 = '0; raddr2 = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        req0_valid = 1; req1_valid = 1; req0_waddr = 5'd3; req1_waddr = 5'd4;
        raddr1 = 5'd3; raddr2 = 5'd4;
        #3;
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready: got %b%b want 00", req0_ready, req1_ready);
        end
        checks++;
        if (rf_valid !== 1'b0 || hazard1 !== 1'b0 || hazard2 !== 1'b0) begin
            errors++; $display("FAIL reset_valid_hazard: got %b%b%b want 000", rf_valid, hazard1, hazard2);
        end
        checks++;
        if (rf_waddr !== '0 || rf_wdata !== '0 || rf_src !== 1'b0) begin
            errors++; $display("FAIL reset_hold: got %h %h %b want 0", rf_waddr, rf_wdata, rf_src);
        end
        checks++;
        if (grant_cnt0 !== 32'd0 || grant_cnt1 !== 32'd0) begin
            errors++; $display("FAIL reset_cnt: got %0d %0d want 0 0", grant_cnt0, grant_cnt1);
        end
        @(posedge clock);
        #1;
        idle_inputs();
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_single_write();
        req0_valid = 1; req0_waddr = 5'd5; req0_wdata = 32'hDEADBEEF; rf_ready = 1;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || rf_valid !== 1'b0) begin
            errors++; $display("FAIL single_accept: ready %b rf_valid %b want 1 0", req0_ready, rf_valid);
        end
        tick();
        req0_valid = 0;
        #1;
        checks++;
        if (rf_valid !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF || rf_src !== 1'b0) begin
            errors++; $display("FAIL single_write: got v%b a%0d d%h s%b want v1 a5 dDEADBEEF s0",
                               rf_valid, rf_waddr, rf_wdata, rf_src);
        end
        tick();
        #1;
        checks++;
        if (rf_valid !== 1'b0) begin
            errors++; $display("FAIL single_pulse: rf_valid %b want 0", rf_valid);
        end
        checks++;
        if (grant_cnt0 !== (32'd1 & STAT_MASK)) begin
            errors++; $display("FAIL single_cnt0: got %0d want %0d", grant_cnt0, 32'd1 & STAT_MASK);
        end
    endtask

    task automatic test_alternate();
        do_reset();
        req0_valid = 1; req1_valid = 1; req0_waddr = 5'd3; req1_waddr = 5'd4; rf_ready = 1;
        for (int i = 0; i < 8; i++) begin
            req0_wdata = $urandom(); req1_wdata = $urandom();
            #1;
            checks++;
            if (i % 2 == 0) begin
                if (rf_valid !== 1'b0 || req0_ready !== (i % 4 == 0) || req1_ready !== (i % 4 == 2)) begin
                    errors++; $display("FAIL alt_grant cycle %0d: v%b r0%b r1%b", i, rf_valid, req0_ready, req1_ready);
                end
            end else begin
                if (rf_valid !== 1'b1 || rf_src !== (i % 4 == 3) || rf_waddr !== ((i % 4 == 3) ? 5'd4 : 5'd3)) begin
                    errors++; $display("FAIL alt_write cycle %0d: v%b s%b a%0d", i, rf_valid, rf_src, rf_waddr);
                end
            end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] d;
        do_reset();
        d = $urandom();
        req0_valid = 1; req0_waddr = 5'd9; req0_wdata = d; req1_valid = 1; req1_waddr = 5'd2;
        rf_ready = 0;
        tick();
        for (int i = 0; i < 5; i++) begin
            req0_valid = 1'($urandom()); req1_valid = 1;
            req0_waddr = 5'($urandom()); req0_wdata = $urandom();
            req1_waddr = 5'($urandom()); req1_wdata = $urandom();
            #1;
            checks++;
            if (rf_valid !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== d || rf_src !== 1'b0
                || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                errors++; $display("FAIL bp_stable cycle %0d: v%b a%0d d%h s%b r%b%b want a9 d%h",
                                   i, rf_valid, rf_waddr, rf_wdata, rf_src, req0_ready, req1_ready, d);
            end
            tick();
        end
        req0_valid = 0; req1_valid = 0; rf_ready = 1;
        tick();
        #1;
        checks++;
        if (rf_valid !== 1'b0) begin
            errors++; $display("FAIL bp_release: rf_valid %b want 0", rf_valid);
        end
        idle_inputs();
    endtask

    task automatic test_zero_addr();
        do_reset();
        req1_valid = 1; req1_waddr = 5'd0; req1_wdata = $urandom();
        #1;
        checks++;
        if (req1_ready !== 1'b1) begin
            errors++; $display("FAIL zero_accept: ready1 %b want 1", req1_ready);
        end
        tick();
        req1_valid = 0;
        #1;
        checks++;
        if (rf_valid !== 1'b0) begin
            errors++; $display("FAIL zero_no_write: rf_valid %b want 0", rf_valid);
        end
        checks++;
        if (grant_cnt1 !== (32'd1 & STAT_MASK) || grant_cnt0 !== 32'd0) begin
            errors++; $display("FAIL zero_cnt: got %0d %0d want 0 %0d", grant_cnt0, grant_cnt1, 32'd1 & STAT_MASK);
        end
        // Pointer moved to requester 1, so it now wins a tie.
        req0_valid = 1; req1_valid = 1; req0_waddr = 5'd6; req1_waddr = 5'd8;
        #1;
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin
            errors++; $display("FAIL zero_ptr: r0%b r1%b want 01", req0_ready, req1_ready);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_hazard();
        do_reset();
        req0_valid = 1; req0_waddr = 5'd7; rf_ready = 0;
        tick();
        req0_valid = 0; raddr1 = 5'd7; raddr2 = 5'd0;
        #1;
        checks++;
        if (hazard1 !== 1'b1 || hazard2 !== 1'b0) begin
            errors++; $display("FAIL hazard_r1: got %b%b want 10", hazard1, hazard2);
        end
        raddr1 = 5'd6; raddr2 = 5'd7;
        #1;
        checks++;
        if (hazard1 !== 1'b0 || hazard2 !== 1'b1) begin
            errors++; $display("FAIL hazard_r2: got %b%b want 01", hazard1, hazard2);
        end
        rf_ready = 1;
        tick();
        raddr1 = 5'd7;
        #1;
        checks++;
        if (hazard1 !== 1'b0 || hazard2 !== 1'b0) begin
            errors++; $display("FAIL hazard_idle: got %b%b want 00", hazard1, hazard2);
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        do_reset();
        req0_valid = 1; req0_waddr = 5'd12; req0_wdata = $urandom(); rf_ready = 0;
        tick();
        req0_valid = 1; req1_valid = 1; req1_waddr = 5'd13; raddr1 = 5'd12;
        #1;
        checks++;
        if (rf_valid !== 1'b1) begin
            errors++; $display("FAIL areset_pre: rf_valid %b want 1", rf_valid);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (rf_valid !== 1'b0 || rf_waddr !== '0 || rf_wdata !== '0 || rf_src !== 1'b0) begin
            errors++; $display("FAIL areset_clear: v%b a%0d d%h s%b want 0", rf_valid, rf_waddr, rf_wdata, rf_src);
        end
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || hazard1 !== 1'b0) begin
            errors++; $display("FAIL areset_ready: r%b%b h%b want 000", req0_ready, req1_ready, hazard1);
        end
        @(posedge clock);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++; $display("FAIL areset_first_arb: r0%b r1%b want 10", req0_ready, req1_ready);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        bit            e0, e1, eh1, eh2;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 3) != 0);
            req0_waddr = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom());
            req1_waddr = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom());
            req0_wdata = $urandom(); req1_wdata = $urandom();
            rf_ready   = ($urandom_range(0, 2) != 0);
            raddr1     = ($urandom_range(0, 1) == 0) ? m_addr : 5'($urandom());
            raddr2     = ($urandom_range(0, 2) == 0) ? m_addr : 5'($urandom());
            #1;
            e0  = win0();
            e1  = win1();
            eh1 = m_hold && (raddr1 == m_addr) && (raddr1 != 0);
            eh2 = m_hold && (raddr2 == m_addr) && (raddr2 != 0);
            checks++;
            if (req0_ready !== e0 || req1_ready !== e1) begin
                errors++; $display("FAIL rnd_ready cycle %0d: got %b%b want %b%b", i, req0_ready, req1_ready, e0, e1);
            end
            checks++;
            if (rf_valid !== m_hold || rf_waddr !== m_addr || rf_wdata !== m_data || rf_src !== m_src) begin
                errors++; $display("FAIL rnd_rf cycle %0d: got v%b a%0d d%h s%b want v%b a%0d d%h s%b",
                                   i, rf_valid, rf_waddr, rf_wdata, rf_src, m_hold, m_addr, m_data, m_src);
            end
            checks++;
            if (hazard1 !== eh1 || hazard2 !== eh2) begin
                errors++; $display("FAIL rnd_hazard cycle %0d: got %b%b want %b%b", i, hazard1, hazard2, eh1, eh2);
            end
            checks++;
            if (grant_cnt0 !== (m_cnt0 & STAT_MASK) || grant_cnt1 !== (m_cnt1 & STAT_MASK)) begin
                errors++; $display("FAIL rnd_cnt cycle %0d: got %0d %0d want %0d %0d", i,
                                   grant_cnt0, grant_cnt1, m_cnt0 & STAT_MASK, m_cnt1 & STAT_MASK);
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_write();
        test_alternate();
        test_backpressure();
        test_zero_addr();
        test_hazard();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
